// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, FSM states and helpers for data_memory_pipe.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // One response beat as it travels down the latency pipe.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] rdata;
  } rsp_t;

  // True when a halfword sits on an odd address or a word is not 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: LATENCY-deep shift register carrying {valid, fault, rdata}.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);

  rsp_t r_stage [LATENCY];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_rsp;
      for (int s = 1; s < LATENCY; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_rsp = r_stage[LATENCY-1];

endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressed, big-endian data memory with a valid/ready
// request port, a fixed-latency response pipe and a clear sweep after reset.
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_rw,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_fault
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SWEEP = DEPTH / 4;
  localparam int PTR_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [7:0]        r_mem [DEPTH];
  state_t            r_state;
  logic              r_ready;
  logic [PTR_W-1:0]  r_ptr;

  logic              w_accept;
  logic              w_fault;
  logic              w_sign;
  logic [ADDR_W-1:0] w_addr  [4];
  logic [7:0]        w_rbyte [4];
  logic [7:0]        w_wbyte [4];
  logic [3:0]        w_wen;
  logic [31:0]       w_rdata;
  rsp_t              w_rsp;
  rsp_t              w_rsp_out;

  assign w_accept = i_req_valid && r_ready;
  assign w_fault  = (i_req_size == SIZE_RSVD) ||
                    ((ALIGN_CHECK != 0) && is_misaligned(i_req_size, i_req_addr[1:0]));

  // INIT sweeps the array clear four bytes per cycle, then RUN accepts every cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_ready <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == PTR_W'(SWEEP - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Byte lane addresses wrap modulo DEPTH; read lanes sample the array directly.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_addr[k]  = i_req_addr + ADDR_W'(k);
      w_rbyte[k] = r_mem[w_addr[k]];
    end
  end

  // Steer store data onto byte lanes, most significant byte at the lowest address.
  always_comb begin
    w_wen = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_wbyte[k] = 8'h00;
    end
    case (i_req_size)
      SIZE_BYTE: begin
        w_wen      = 4'b0001;
        w_wbyte[0] = i_req_wdata[7:0];
      end
      SIZE_HALF: begin
        w_wen      = 4'b0011;
        w_wbyte[0] = i_req_wdata[15:8];
        w_wbyte[1] = i_req_wdata[7:0];
      end
      SIZE_WORD: begin
        w_wen      = 4'b1111;
        w_wbyte[0] = i_req_wdata[31:24];
        w_wbyte[1] = i_req_wdata[23:16];
        w_wbyte[2] = i_req_wdata[15:8];
        w_wbyte[3] = i_req_wdata[7:0];
      end
      default: w_wen = 4'b0000;
    endcase
    if (!w_accept || !i_req_rw || w_fault) begin
      w_wen = 4'b0000;
    end
  end

  // Assemble load bytes big-endian and extend from the top byte when signed.
  always_comb begin
    w_sign = i_req_signed & w_rbyte[0][7];
    case (i_req_size)
      SIZE_BYTE: w_rdata = {{24{w_sign}}, w_rbyte[0]};
      SIZE_HALF: w_rdata = {{16{w_sign}}, w_rbyte[0], w_rbyte[1]};
      SIZE_WORD: w_rdata = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
      default:   w_rdata = 32'h0000_0000;
    endcase
    if (!w_accept || i_req_rw || w_fault) begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Array writes: zero fill during INIT, enabled store lanes during RUN.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int k = 0; k < 4; k++) begin
        if (r_state == ST_INIT) begin
          r_mem[ADDR_W'({r_ptr, 2'(k)})] <= 8'h00;
        end else if (w_wen[k]) begin
          r_mem[w_addr[k]] <= w_wbyte[k];
        end
      end
    end
  end

  assign w_rsp = '{valid: w_accept, fault: w_accept && w_fault, rdata: w_rdata};

  dmem_rsp_pipe #(
    .LATENCY(LATENCY)
  ) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_rsp   (w_rsp),
    .o_rsp   (w_rsp_out)
  );

  assign o_req_ready = r_ready;
  assign o_rsp_valid = w_rsp_out.valid;
  assign o_rsp_fault = w_rsp_out.fault;
  assign o_rsp_rdata = w_rsp_out.rdata;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: drives two instances with shared stimulus, one with
// LATENCY 3 and alignment checking, one with LATENCY 1 and wrapping accesses,
// and compares both against a byte-array reference model.
module tb_data_memory_pipe;

  localparam int DEPTH = 256;
  localparam int SWEEP = DEPTH / 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqRw = 1'b0;
  logic [1:0]  reqSize = 2'd0;
  logic        reqSigned = 1'b0;
  logic [7:0]  reqAddr = 8'h00;
  logic [31:0] reqWdata = 32'h0;

  logic        readyA, validA, faultA;
  logic [31:0] rdataA;
  logic        readyB, validB, faultB;
  logic [31:0] rdataB;

  always #5 clk = ~clk;

  data_memory_pipe #(.ADDR_W(8), .LATENCY(3), .ALIGN_CHECK(1)) dutA (
    .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(readyA),
    .i_req_rw(reqRw), .i_req_size(reqSize), .i_req_signed(reqSigned),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_rsp_valid(validA), .o_rsp_rdata(rdataA), .o_rsp_fault(faultA)
  );

  data_memory_pipe #(.ADDR_W(8), .LATENCY(1), .ALIGN_CHECK(0)) dutB (
    .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(readyB),
    .i_req_rw(reqRw), .i_req_size(reqSize), .i_req_signed(reqSigned),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_rsp_valid(validB), .o_rsp_rdata(rdataB), .o_rsp_fault(faultB)
  );

  // Expected response: which instance, the cycle it must be visible, and its payload.
  typedef struct {
    int          dut;
    int          due;
    logic        fault;
    logic [31:0] data;
  } expRsp_t;

  expRsp_t    expQ[$];
  logic [7:0] refMem [2][DEPTH];
  bit         modelRun;
  bit         resetSeen;
  int         sweepCount;
  int         cycleNum;
  int         checkCount;
  int         errorCount;

  function automatic int latOf(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic bit alignChecked(input int d);
    return (d == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleNum);
    end
  endtask

  // Reference behaviour of one accepted request for instance d.
  function automatic void modelAccess(input int d);
    int          n;
    logic        f;
    logic [7:0]  ad;
    logic [31:0] val;
    n   = (reqSize == 2'd0) ? 1 : (reqSize == 2'd1) ? 2 : 4;
    f   = (reqSize == 2'd3);
    val = 32'h0;
    if (alignChecked(d) && ((int'(reqAddr) % n) != 0)) f = 1'b1;
    if (!f) begin
      for (int k = 0; k < n; k++) begin
        ad = reqAddr + 8'(k);
        if (reqRw) refMem[d][ad] = reqWdata[8*(n-1-k) +: 8];
        else       val = (val << 8) | 32'(refMem[d][ad]);
      end
      if (!reqRw && reqSigned && n < 4 && val >= (32'd1 << (8*n - 1)))
        val = val - (32'd1 << (8*n));
    end
    expQ.push_back('{d, cycleNum + latOf(d) - 1, f, val});
  endfunction

  function automatic void modelEdge();
    cycleNum++;
    resetSeen = reset;
    if (reset) begin
      modelRun   = 1'b0;
      sweepCount = 0;
      expQ.delete();
      for (int d = 0; d < 2; d++)
        for (int a = 0; a < DEPTH; a++)
          refMem[d][a] = 8'h00;
    end else if (!modelRun) begin
      sweepCount++;
      if (sweepCount == SWEEP) modelRun = 1'b1;
    end else if (reqValid) begin
      modelAccess(0);
      modelAccess(1);
    end
  endfunction

  task automatic checkDut(input int d, input logic v, input logic f, input logic [31:0] data);
    string       nm;
    bit          found;
    logic        ef;
    logic [31:0] ed;
    nm    = (d == 0) ? "A" : "B";
    found = 1'b0;
    ef    = 1'b0;
    ed    = 32'h0;
    foreach (expQ[i]) begin
      if (expQ[i].dut == d && expQ[i].due == cycleNum) begin
        found = 1'b1;
        ef    = expQ[i].fault;
        ed    = expQ[i].data;
      end
    end
    checkOutput({nm, ".rspValid"}, 32'(v), 32'(found));
    if (found) begin
      checkOutput({nm, ".rspFault"}, 32'(f), 32'(ef));
      checkOutput({nm, ".rspRdata"}, data, ed);
    end
    if (resetSeen) begin
      checkOutput({nm, ".resetRdata"}, data, 32'h0);
      checkOutput({nm, ".resetFault"}, 32'(f), 32'h0);
    end
  endtask

  task automatic checkCycle();
    expRsp_t keep[$];
    checkOutput("A.ready", 32'(readyA), 32'(modelRun));
    checkOutput("B.ready", 32'(readyB), 32'(modelRun));
    checkDut(0, validA, faultA, rdataA);
    checkDut(1, validB, faultB, rdataB);
    foreach (expQ[i]) if (expQ[i].due > cycleNum) keep.push_back(expQ[i]);
    expQ = keep;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkCycle();
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] sz,
                               input logic sg, input logic [7:0] a, input logic [31:0] wd);
    reqValid  = v;
    reqRw     = rw;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = a;
    reqWdata  = wd;
    stepCycle();
  endtask

  task automatic idle(input int n);
    reqValid = 1'b0;
    repeat (n) stepCycle();
  endtask

  task automatic randomizeReq(input int validPct);
    int sel;
    reqValid  = ($urandom_range(0, 99) < validPct);
    reqRw     = 1'($urandom_range(0, 1));
    reqSize   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    reqSigned = 1'($urandom_range(0, 1));
    reqWdata  = $urandom;
    sel       = $urandom_range(0, 3);
    case (sel)
      0:       reqAddr = 8'($urandom_range(0, 255));
      3:       reqAddr = 8'($urandom_range(248, 255));
      default: reqAddr = 8'($urandom_range(0, 31));
    endcase
  endtask

  // Counts edges with reset low until ready is seen, junk on the request port meanwhile.
  task automatic waitReady(output int n);
    n = 0;
    do begin
      randomizeReq(50);
      stepCycle();
      n++;
    end while (!readyA && n < 200);
    reqValid = 1'b0;
  endtask

  initial begin
    int n;
    checkCount = 0;
    errorCount = 0;
    cycleNum   = 0;
    modelRun   = 1'b0;
    sweepCount = 0;
    $display("[TB] start");

    reset = 1'b1;
    repeat (3) stepCycle();
    reset = 1'b0;
    waitReady(n);
    checkOutput("initCycles", 32'(n), 32'(SWEEP));

    applyStimulus(1, 0, 2'd2, 0, 8'h40, 32'h0);
    applyStimulus(1, 1, 2'd2, 0, 8'h10, 32'h11223344);
    applyStimulus(1, 0, 2'd0, 0, 8'h10, 32'h0);
    applyStimulus(1, 0, 2'd1, 0, 8'h12, 32'h0);
    applyStimulus(1, 1, 2'd0, 0, 8'h05, 32'h00000080);
    applyStimulus(1, 0, 2'd0, 1, 8'h05, 32'h0);
    applyStimulus(1, 0, 2'd0, 0, 8'h05, 32'h0);
    applyStimulus(1, 1, 2'd2, 0, 8'h21, 32'hDEADBEEF);
    applyStimulus(1, 0, 2'd2, 0, 8'h20, 32'h0);
    applyStimulus(1, 0, 2'd1, 0, 8'h03, 32'h0);
    applyStimulus(1, 0, 2'd3, 0, 8'h08, 32'h0);
    applyStimulus(1, 1, 2'd2, 0, 8'hFE, 32'hAABBCCDD);
    applyStimulus(1, 0, 2'd0, 0, 8'hFF, 32'h0);
    applyStimulus(1, 0, 2'd1, 0, 8'h00, 32'h0);
    applyStimulus(1, 0, 2'd1, 1, 8'h12, 32'h0);
    idle(4);

    applyStimulus(1, 0, 2'd2, 0, 8'h10, 32'h0);
    applyStimulus(1, 0, 2'd2, 0, 8'h14, 32'h0);
    reqValid = 1'b0;
    reset    = 1'b1;
    repeat (2) stepCycle();
    reset = 1'b0;
    repeat (20) begin
      randomizeReq(50);
      stepCycle();
    end
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    waitReady(n);
    checkOutput("reinitCycles", 32'(n), 32'(SWEEP));
    applyStimulus(1, 0, 2'd2, 0, 8'h10, 32'h0);
    applyStimulus(1, 0, 2'd2, 0, 8'hFC, 32'h0);
    idle(4);

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        randomizeReq(50);
        stepCycle();
        reset = 1'b0;
        waitReady(n);
        checkOutput("randInitCycles", 32'(n), 32'(SWEEP));
      end else begin
        randomizeReq(70);
        stepCycle();
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
